// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Processor-side memory access controller sitting upstream of ram_256b.
//   Accepts one load/store request at a time, runs the RAM MFA/MFC handshake
//   (setup, assert MFA, wait MFC, release) and returns read data or an error.
//   RAM address/opcode/data are registered at accept and held stable for the
//   whole transaction; WAIT_MFC and RELEASE are bounded by a timeout.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake, accepted when valid & ready
//   req_opcode        6-bit memory opcode
//   req_addr          byte address
//   req_wdata         store data, right-justified
//   resp_valid        one-cycle response strobe
//   resp_rdata        load data, zero-extended; 0 for stores and errors
//   resp_err          00 ok, 01 misaligned, 10 timeout, 11 bad opcode
//   busy              controller not idle
//   mem_mfa           memory function active to RAM
//   mem_opcode        opcode to RAM
//   mem_addr          address to RAM
//   mem_data_in       write data to RAM
//   mem_mfc           memory function complete from RAM (asynchronous)
//   mem_data_out      read data from RAM
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SETUP_CYC   = 3,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic              busy,
  output logic              mem_mfa,
  output logic [5:0]        mem_opcode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  input  logic              mem_mfc,
  input  logic [31:0]       mem_data_out
);

  localparam logic [5:0] OP_SW = 6'h04;
  localparam logic [5:0] OP_SB = 6'h05;
  localparam logic [5:0] OP_SH = 6'h06;
  localparam logic [5:0] OP_LW = 6'h08;
  localparam logic [5:0] OP_LB = 6'h09;
  localparam logic [5:0] OP_LH = 6'h0A;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_OPC   = 2'b11;

  localparam int unsigned SCW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT_MFC,
    S_RELEASE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [1:0]          err_q;
  logic                mfa_q, mfa_d;
  logic [SCW-1:0]      setup_cnt_q, setup_cnt_d;
  logic [TCW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;

  logic        mfc_s;
  logic        accept;
  logic        req_bad_op;
  logic        req_misal;
  logic        setup_done;
  logic        tmo_hit;
  logic        mfc_hit;
  logic        op_is_load;
  logic [31:0] load_data;

  // ---------------------------------------------------------------------------
  // MFC synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mem_mfc};
    end
  end

  assign mfc_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Request decode (bad opcode takes priority over misalignment)
  // ---------------------------------------------------------------------------
  always_comb begin
    req_bad_op = 1'b0;
    req_misal  = 1'b0;
    case (req_opcode)
      OP_SW, OP_LW: req_misal  = (req_addr[1:0] != 2'b00);
      OP_SH, OP_LH: req_misal  = req_addr[0];
      OP_SB, OP_LB: req_misal  = 1'b0;
      default:      req_bad_op = 1'b1;
    endcase
  end

  // Load size selection on the registered opcode
  always_comb begin
    op_is_load = 1'b0;
    load_data  = '0;
    case (op_q)
      OP_LW: begin
        op_is_load = 1'b1;
        load_data  = mem_data_out;
      end
      OP_LH: begin
        op_is_load = 1'b1;
        load_data  = {16'h0000, mem_data_out[15:0]};
      end
      OP_LB: begin
        op_is_load = 1'b1;
        load_data  = {24'h000000, mem_data_out[7:0]};
      end
      default: ;
    endcase
  end

  assign accept     = req_valid && (state_q == S_IDLE);
  assign setup_done = (setup_cnt_q == SCW'(SETUP_CYC - 1));
  assign tmo_hit    = (tmo_cnt_q == TCW'(TIMEOUT_CYC - 1));
  // MFC is only honoured once MFA is actually on the wire, so anything left in
  // the synchronizer from SETUP cannot complete the transaction early.
  assign mfc_hit    = mfa_q && mfc_s;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (req_bad_op || req_misal) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_done) state_d = S_WAIT_MFC;
      end
      S_WAIT_MFC: begin
        if (mfc_hit || tmo_hit) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!mfc_s || tmo_hit) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and MFA register
  // ---------------------------------------------------------------------------
  always_comb begin
    setup_cnt_d = '0;
    tmo_cnt_d   = '0;
    if (state_d == state_q) begin
      if (state_q == S_SETUP) begin
        setup_cnt_d = setup_cnt_q + SCW'(1);
      end
      if ((state_q == S_WAIT_MFC) || (state_q == S_RELEASE)) begin
        tmo_cnt_d = (tmo_cnt_q == TCW'(TIMEOUT_CYC)) ? tmo_cnt_q : tmo_cnt_q + TCW'(1);
      end
    end
  end

  // MFA is registered: it rises at the end of the first WAIT_MFC cycle and
  // falls on the edge that leaves WAIT_MFC (MFC seen or timeout).
  assign mfa_d = (state_q == S_WAIT_MFC) && (state_d == S_WAIT_MFC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      setup_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      mfa_q       <= 1'b0;
    end else begin
      setup_cnt_q <= setup_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mfa_q       <= mfa_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else if (accept) begin
      op_q    <= req_opcode;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
      if (req_bad_op)     err_q <= ERR_OPC;
      else if (req_misal) err_q <= ERR_ALIGN;
      else                err_q <= ERR_OK;
    end else if (state_q == S_WAIT_MFC) begin
      if (mfc_hit) begin
        if (op_is_load) rdata_q <= load_data;
      end else if (tmo_hit) begin
        err_q   <= ERR_TMO;
        rdata_q <= '0;
      end
    end else if ((state_q == S_RELEASE) && mfc_s && tmo_hit) begin
      err_q   <= ERR_TMO;
      rdata_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    resp_valid  = (state_q == S_DONE);
    resp_rdata  = (state_q == S_DONE) ? rdata_q : '0;
    resp_err    = (state_q == S_DONE) ? err_q : ERR_OK;
    mem_mfa     = mfa_q;
    mem_opcode  = op_q;
    mem_addr    = addr_q;
    mem_data_in = wdata_q;
  end

endmodule
